regfile_ctrl: RTL and testbench

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl_pkg.sv | 56 +++++
 rtl/regfile_ctrl_onehot_dec.sv | 23 ++
 rtl/regfile_ctrl.sv | 133 +++++++++++++
 tb/tb_regfile_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the two-stage register-file controller: opcodes, ALU
// function codes, the in-flight instruction record and small decode helpers.
package regfile_ctrl_pkg;

    // Widest register address supported (NREG up to 16); narrower configs zero-extend.
    localparam int MAX_AW = 4;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_PASS = 3'b110,
        OP_CMP  = 3'b111
    } op_e;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_CMP  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b1000;

    typedef struct packed {
        op_e               op;
        logic [MAX_AW-1:0] a;
        logic [MAX_AW-1:0] b;
        logic [MAX_AW-1:0] w;
        logic [1:0]        sh;
        logic [1:0]        sel;
    } instr_t;

    function automatic logic [3:0] alu_decode(input op_e op);
        case (op)
            OP_NOP:  return ALU_NOP;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_PASS: return ALU_PASS;
            OP_CMP:  return ALU_CMP;
            default: return ALU_NOP;
        endcase
    endfunction

    // NOP and CMP produce no register-file result.
    function automatic logic op_writes(input op_e op);
        return (op != OP_NOP) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/regfile_ctrl_onehot_dec.sv
// Enable-gated binary to one-hot decoder used for register read/write enables.
module onehot_dec #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_en,
    input  logic [IW-1:0] i_idx,
    output logic [N-1:0]  o_oh
);

    // One bit per register, set only for the addressed one while enabled.
    always_comb begin
        o_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (i_en && (i_idx == IW'(i))) begin
                o_oh[i] = 1'b1;
            end else begin
                o_oh[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Two-stage (decode/read, execute/write) register-file controller with
// W-to-D bypass requests, stall hold and a retired-write counter.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int  NREG = 4,
    parameter int  CW   = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ctrl_op,
    input  logic [AW-1:0]   ctrl_a,
    input  logic [AW-1:0]   ctrl_b,
    input  logic [AW-1:0]   ctrl_w,
    input  logic [1:0]      ctrl_sh,
    input  logic [1:0]      ctrl_sel,
    input  logic            stall,
    output logic [NREG-1:0] a_rd_en,
    output logic [NREG-1:0] b_rd_en,
    output logic            a_sel,
    output logic            b_sel,
    output logic            d_sel,
    output logic            zero_sel,
    output logic            fwd_a,
    output logic            fwd_b,
    output logic [NREG-1:0] wr_en,
    output logic [3:0]      alu_fn,
    output logic            shl,
    output logic            shr,
    output logic [CW-1:0]   retired
);

    logic              r_d_valid;
    instr_t            r_d;
    logic              r_w_valid;
    op_e               r_w_op;
    logic [MAX_AW-1:0] r_w_addr;
    logic [1:0]        r_w_sh;
    logic [CW-1:0]     r_retired;

    instr_t            w_in;
    logic              w_writing;

    assign w_in = '{op:  op_e'(ctrl_op),
                    a:   MAX_AW'(ctrl_a),
                    b:   MAX_AW'(ctrl_b),
                    w:   MAX_AW'(ctrl_w),
                    sh:  ctrl_sh,
                    sel: ctrl_sel};

    assign in_ready  = !stall;
    assign w_writing = r_w_valid && op_writes(r_w_op) && !stall;
    assign retired   = r_retired;

    // Pipeline advance: D moves to W and D reloads on every non-stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d       <= '0;
            r_w_valid <= 1'b0;
            r_w_op    <= OP_NOP;
            r_w_addr  <= '0;
            r_w_sh    <= 2'b00;
            r_retired <= '0;
        end else if (!stall) begin
            r_w_valid <= r_d_valid;
            r_w_op    <= r_d.op;
            r_w_addr  <= r_d.w;
            r_w_sh    <= r_d.sh;
            r_d_valid <= in_valid;
            if (in_valid) begin
                r_d <= w_in;
            end
            if (w_writing) begin
                r_retired <= r_retired + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    onehot_dec #(.N(NREG), .IW(MAX_AW)) u_dec_a (
        .i_en (r_d_valid),
        .i_idx(r_d.a),
        .o_oh (a_rd_en)
    );

    onehot_dec #(.N(NREG), .IW(MAX_AW)) u_dec_b (
        .i_en (r_d_valid),
        .i_idx(r_d.b),
        .o_oh (b_rd_en)
    );

    onehot_dec #(.N(NREG), .IW(MAX_AW)) u_dec_w (
        .i_en (w_writing),
        .i_idx(r_w_addr),
        .o_oh (wr_en)
    );

    // Operand selects and bypass requests come from the D stage.
    always_comb begin
        if (r_d_valid) begin
            d_sel    = r_d.sel[0];
            b_sel    = !r_d.sel[0];
            zero_sel = r_d.sel[1];
            a_sel    = !r_d.sel[1];
            fwd_a    = w_writing && (r_d.a == r_w_addr);
            fwd_b    = w_writing && (r_d.b == r_w_addr);
        end else begin
            d_sel    = 1'b0;
            b_sel    = 1'b0;
            zero_sel = 1'b0;
            a_sel    = 1'b0;
            fwd_a    = 1'b0;
            fwd_b    = 1'b0;
        end
    end

    // ALU function and shift controls come from the W stage.
    always_comb begin
        if (r_w_valid) begin
            alu_fn = alu_decode(r_w_op);
            shl    = (r_w_sh == 2'b01);
            shr    = (r_w_sh == 2'b10);
        end else begin
            alu_fn = ALU_NOP;
            shl    = 1'b0;
            shr    = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl (NREG=4, CW=4): directed scenarios plus
// randomized traffic compared against a cycle-level pipeline model.
module tb_regfile_ctrl;

    localparam int NREG = 4;
    localparam int AW   = 2;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      ctrl_op;
    logic [AW-1:0]   ctrl_a, ctrl_b, ctrl_w;
    logic [1:0]      ctrl_sh, ctrl_sel;
    logic            stall;
    logic [NREG-1:0] a_rd_en, b_rd_en, wr_en;
    logic            a_sel, b_sel, d_sel, zero_sel, fwd_a, fwd_b, shl, shr;
    logic [3:0]      alu_fn;
    logic [CW-1:0]   retired;

    always #5 clk = ~clk;

    regfile_ctrl #(.NREG(NREG), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_op(ctrl_op), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b), .ctrl_w(ctrl_w),
        .ctrl_sh(ctrl_sh), .ctrl_sel(ctrl_sel), .stall(stall),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_sel(a_sel), .b_sel(b_sel),
        .d_sel(d_sel), .zero_sel(zero_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .wr_en(wr_en), .alu_fn(alu_fn), .shl(shl), .shr(shr), .retired(retired)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instruction sitting in each stage, plus a write tally.
    logic          m_d_valid, m_w_valid;
    logic [2:0]    m_d_op, m_w_op;
    logic [AW-1:0] m_d_a, m_d_b, m_d_w, m_w_w;
    logic [1:0]    m_d_sh, m_d_sel, m_w_sh;
    logic [CW-1:0] m_ret;

    logic [3:0] alu_tab [0:7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h3};

    wire [28:0] dut_o = {in_ready, a_rd_en, b_rd_en, a_sel, b_sel, d_sel, zero_sel,
                         fwd_a, fwd_b, wr_en, alu_fn, shl, shr, retired};

    function automatic logic model_writing();
        return m_w_valid && (m_w_op != 3'd0) && (m_w_op != 3'd7) && !stall;
    endfunction

    function automatic logic [28:0] exp_o();
        logic       wrt;
        logic [3:0] ard, brd, wr, alu;
        wrt = model_writing();
        ard = m_d_valid ? (4'd1 << m_d_a) : 4'd0;
        brd = m_d_valid ? (4'd1 << m_d_b) : 4'd0;
        wr  = wrt ? (4'd1 << m_w_w) : 4'd0;
        alu = m_w_valid ? alu_tab[m_w_op] : 4'd0;
        return {!stall, ard, brd,
                m_d_valid && !m_d_sel[1], m_d_valid && !m_d_sel[0],
                m_d_valid && m_d_sel[0], m_d_valid && m_d_sel[1],
                m_d_valid && wrt && (m_d_a == m_w_w),
                m_d_valid && wrt && (m_d_b == m_w_w),
                wr, alu,
                m_w_valid && (m_w_sh == 2'b01), m_w_valid && (m_w_sh == 2'b10),
                m_ret};
    endfunction

    task automatic model_clear();
        m_d_valid = 1'b0; m_w_valid = 1'b0;
        m_d_op = 3'd0; m_w_op = 3'd0;
        m_d_a = '0; m_d_b = '0; m_d_w = '0; m_w_w = '0;
        m_d_sh = 2'b00; m_d_sel = 2'b00; m_w_sh = 2'b00;
        m_ret = '0;
    endtask

    // Apply inputs just after a rising edge and move to the sampling point.
    task automatic drv(input logic v, input logic [2:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] w,
                       input logic [1:0] sh, input logic [1:0] sel, input logic st);
        in_valid = v; ctrl_op = op; ctrl_a = a; ctrl_b = b; ctrl_w = w;
        ctrl_sh = sh; ctrl_sel = sel; stall = st;
        @(negedge clk);
    endtask

    task automatic advance();
        logic wrt;
        wrt = model_writing();
        @(posedge clk);
        if (rst_n && !stall) begin
            if (wrt) m_ret = m_ret + 4'd1;
            m_w_valid = m_d_valid; m_w_op = m_d_op; m_w_w = m_d_w; m_w_sh = m_d_sh;
            m_d_valid = in_valid;
            if (in_valid) begin
                m_d_op = ctrl_op; m_d_a = ctrl_a; m_d_b = ctrl_b; m_d_w = ctrl_w;
                m_d_sh = ctrl_sh; m_d_sel = ctrl_sel;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 3'd1, 2'd1, 2'd2, 2'd3, 2'b01, 2'b11, i[0]);
            n_checks++;
            if (dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", dut_o, exp_o());
            end
            advance();
        end
        rst_n = 1'b1;
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (retired !== 4'd0 || wr_en !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: got retired=%h wr_en=%b expected 0 and 0000", retired, wr_en);
        end
        advance();
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
            n_checks++;
            if (dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL flush: got %h expected %h", dut_o, exp_o());
            end
            advance();
        end
    endtask

    task automatic test_read_write();
        logic [CW-1:0] r0;
        flush();
        r0 = m_ret;
        drv(1'b1, 3'd1, 2'd1, 2'd2, 2'd3, 2'b00, 2'b00, 1'b0);
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (a_rd_en !== 4'b0010 || b_rd_en !== 4'b0100 || dut_o !== exp_o()) begin
            n_fail++;
            $display("FAIL add_read: got a=%b b=%b (%h) expected a=0010 b=0100 (%h)", a_rd_en, b_rd_en, dut_o, exp_o());
        end
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (wr_en !== 4'b1000 || alu_fn !== 4'b0001 || retired !== r0) begin
            n_fail++;
            $display("FAIL add_write: got wr=%b alu=%b ret=%0d expected 1000 0001 %0d", wr_en, alu_fn, retired, r0);
        end
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (retired !== r0 + 4'd1) begin
            n_fail++;
            $display("FAIL add_retired: got %0d expected %0d", retired, r0 + 4'd1);
        end
        advance();
    endtask

    task automatic test_forward();
        flush();
        drv(1'b1, 3'd1, 2'd0, 2'd1, 2'd2, 2'b00, 2'b00, 1'b0);
        advance();
        drv(1'b1, 3'd2, 2'd2, 2'd3, 2'd0, 2'b00, 2'b01, 1'b0);
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (fwd_a !== 1'b1 || fwd_b !== 1'b0 || dut_o !== exp_o()) begin
            n_fail++;
            $display("FAIL forward: got fwd_a=%b fwd_b=%b (%h) expected 1 0 (%h)", fwd_a, fwd_b, dut_o, exp_o());
        end
        advance();
    endtask

    task automatic test_stall();
        logic [CW-1:0] r0;
        flush();
        r0 = m_ret;
        drv(1'b1, 3'd1, 2'd3, 2'd0, 2'd1, 2'b00, 2'b00, 1'b0);
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 3'd2, 2'd1, 2'd1, 2'd1, 2'b00, 2'b00, 1'b1);
            n_checks++;
            if (wr_en !== 4'd0 || in_ready !== 1'b0 || retired !== r0 || dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL stall_hold: got wr=%b rdy=%b ret=%0d (%h) expected 0000 0 %0d (%h)", wr_en, in_ready, retired, dut_o, r0, exp_o());
            end
            advance();
        end
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (wr_en !== 4'b0010 || alu_fn !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_release: got wr=%b alu=%b expected 0010 0001", wr_en, alu_fn);
        end
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (retired !== r0 + 4'd1 || wr_en !== 4'd0) begin
            n_fail++;
            $display("FAIL stall_single_write: got ret=%0d wr=%b expected %0d 0000", retired, wr_en, r0 + 4'd1);
        end
        advance();
    endtask

    task automatic test_no_write();
        logic [CW-1:0] r0;
        logic [2:0] ops [0:3];
        ops = '{3'd0, 3'd7, 3'd0, 3'd7};
        flush();
        r0 = m_ret;
        for (int i = 0; i < 6; i++) begin
            drv(i < 4, ops[i % 4], 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
            n_checks++;
            if (wr_en !== 4'd0 || fwd_a !== 1'b0 || fwd_b !== 1'b0 || retired !== r0 || dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL nop_cmp: got wr=%b fwd=%b%b ret=%0d (%h) expected 0000 00 %0d (%h)", wr_en, fwd_a, fwd_b, retired, dut_o, r0, exp_o());
            end
            advance();
        end
    endtask

    task automatic test_shift();
        flush();
        drv(1'b1, 3'd6, 2'd0, 2'd1, 2'd2, 2'b11, 2'b10, 1'b0);
        advance();
        drv(1'b1, 3'd6, 2'd1, 2'd0, 2'd3, 2'b01, 2'b01, 1'b0);
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (shl !== 1'b0 || shr !== 1'b0 || alu_fn !== 4'b1000) begin
            n_fail++;
            $display("FAIL shift_11: got shl=%b shr=%b alu=%b expected 0 0 1000", shl, shr, alu_fn);
        end
        advance();
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (shl !== 1'b1 || shr !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_01: got shl=%b shr=%b expected 1 0", shl, shr);
        end
        advance();
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 18; i++) begin
            drv(i < 16, 3'd1 + 3'($urandom_range(0, 5)), 2'($urandom), 2'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom), 1'b0);
            n_checks++;
            if (dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL wrap_stream: got %h expected %h", dut_o, exp_o());
            end
            advance();
        end
        drv(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (retired !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0d expected 0", retired);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        flush();
        drv(1'b1, 3'd1, 2'd0, 2'd0, 2'd2, 2'b01, 2'b00, 1'b0);
        advance();
        drv(1'b1, 3'd3, 2'd1, 2'd1, 2'd1, 2'b00, 2'b00, 1'b0);
        advance();
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (dut_o !== exp_o()) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", dut_o, exp_o());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(1'b1, 3'd1, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0);
        n_checks++;
        if (wr_en !== 4'd0 || retired !== 4'd0 || dut_o !== exp_o()) begin
            n_fail++;
            $display("FAIL reset_mid_release: got wr=%b ret=%0d (%h) expected 0000 0 (%h)", wr_en, retired, dut_o, exp_o());
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0));
            n_checks++;
            if (dut_o !== exp_o()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_o, exp_o());
            end
            advance();
        end
    endtask

    initial begin
        in_valid = 1'b0; ctrl_op = 3'd0; ctrl_a = '0; ctrl_b = '0; ctrl_w = '0;
        ctrl_sh = 2'b00; ctrl_sel = 2'b00; stall = 1'b0; rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_read_write();
        test_forward();
        test_stall();
        test_no_write();
        test_shift();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
